// File: rtl/tdest_tuser_swap_if.sv
// AXI-Stream bundle for tdest_tuser_swap_reg: upstream beat in (with tdest), downstream beat out (tdest carried as tuser).
// Handshake: a beat transfers on a rising edge where tvalid && tready; tvalid never waits on tready and payload is stable while tvalid && !tready.
interface tdest_tuser_swap_if #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4
);
  localparam int ID_W   = (AXIS_ID_WIDTH   > 1) ? AXIS_ID_WIDTH   : 1;
  localparam int DEST_W = (AXIS_DEST_WIDTH > 1) ? AXIS_DEST_WIDTH : 1;
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata;
  logic [ID_W-1:0]           axis_in_tid;
  logic [DEST_W-1:0]         axis_in_tdest;
  logic [KEEP_W-1:0]         axis_in_tkeep;
  logic                      axis_in_tlast;
  logic                      axis_in_tvalid;
  logic                      axis_in_tready;

  logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata;
  logic [ID_W-1:0]           axis_out_tid;
  logic [DEST_W-1:0]         axis_out_tuser;
  logic [KEEP_W-1:0]         axis_out_tkeep;
  logic                      axis_out_tlast;
  logic                      axis_out_tvalid;
  logic                      axis_out_tready;

  modport slave (
    input  axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tid, axis_out_tuser, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    input  axis_out_tready
  );

  modport master (
    output axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tid, axis_out_tuser, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    output axis_out_tready
  );
endinterface

// File: rtl/tdest_tuser_swap_reg.sv
// Registered AXIS stage (2-entry skid) that carries tdest onto tuser.
// Define TDEST_TUSER_SWAP_PKT_LOCK_EN to lock tuser to each packet's first tdest and count mid-packet tdest changes.
module tdest_tuser_swap_reg #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  tdest_tuser_swap_if.slave        axis,
  output logic                     dest_mismatch,
  output logic [15:0]              mismatch_count,
  output logic                     pkt_mid
);
  localparam int ID_W   = (AXIS_ID_WIDTH   > 1) ? AXIS_ID_WIDTH   : 1;
  localparam int DEST_W = (AXIS_DEST_WIDTH > 1) ? AXIS_DEST_WIDTH : 1;
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0] tdata;
    logic [ID_W-1:0]           tid;
    logic [DEST_W-1:0]         tuser;
    logic [KEEP_W-1:0]         tkeep;
    logic                      tlast;
  } beat_t;

  beat_t             out_q, skid_q, in_beat;
  logic              out_valid, skid_valid, skid_valid_nxt, in_ready;
  logic              accept, drain, out_load;
  logic [DEST_W-1:0] in_user;

  assign accept   = axis.axis_in_tvalid & in_ready;
  assign drain    = out_valid & axis.axis_out_tready;
  assign out_load = ~out_valid | drain;

  assign in_beat.tdata = axis.axis_in_tdata;
  assign in_beat.tid   = axis.axis_in_tid;
  assign in_beat.tuser = in_user;
  assign in_beat.tkeep = axis.axis_in_tkeep;
  assign in_beat.tlast = axis.axis_in_tlast;

  // The skid entry empties whenever the output can take a beat; it fills only on an accept while stalled.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (out_load)
      skid_valid_nxt = 1'b0;
    else if (accept)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      if (out_load)
        out_valid <= skid_valid | accept;
      skid_valid <= skid_valid_nxt;
      in_ready   <= ~skid_valid_nxt;
    end
  end

  // Payload registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge aclk) begin
    if (out_load) begin
      if (skid_valid)
        out_q <= skid_q;
      else if (accept)
        out_q <= in_beat;
    end else if (accept) begin
      skid_q <= in_beat;
    end
  end

  assign axis.axis_in_tready  = in_ready;
  assign axis.axis_out_tvalid = out_valid;
  assign axis.axis_out_tdata  = out_q.tdata;
  assign axis.axis_out_tid    = out_q.tid;
  assign axis.axis_out_tuser  = out_q.tuser;
  assign axis.axis_out_tkeep  = out_q.tkeep;
  assign axis.axis_out_tlast  = out_q.tlast;

`ifdef TDEST_TUSER_SWAP_PKT_LOCK_EN
  typedef enum logic {SOP = 1'b0, MID = 1'b1} state_t;

  state_t            state;
  logic [DEST_W-1:0] lock_dest;
  logic              mismatch_q;
  logic [15:0]       count_q;

  // The first beat of a packet uses its own tdest; later beats reuse the locked value.
  assign in_user = (state == MID) ? lock_dest : axis.axis_in_tdest;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= SOP;
      lock_dest  <= '0;
      mismatch_q <= 1'b0;
      count_q    <= '0;
    end else begin
      mismatch_q <= 1'b0;
      if (accept) begin
        if (state == SOP) begin
          lock_dest <= axis.axis_in_tdest;
          if (!axis.axis_in_tlast)
            state <= MID;
        end else begin
          if (axis.axis_in_tdest != lock_dest) begin
            mismatch_q <= 1'b1;
            if (count_q != 16'hFFFF)
              count_q <= count_q + 16'd1;
          end
          if (axis.axis_in_tlast)
            state <= SOP;
        end
      end
    end
  end

  assign dest_mismatch  = mismatch_q;
  assign mismatch_count = count_q;
  assign pkt_mid        = (state == MID);
`else
  assign in_user        = axis.axis_in_tdest;
  assign dest_mismatch  = 1'b0;
  assign mismatch_count = 16'd0;
  assign pkt_mid        = 1'b0;
`endif
endmodule

// File: tb/tb_tdest_tuser_swap_reg.sv
// Directed bench for tdest_tuser_swap_reg: a driver pushes the hand-computed output beat into exp_q on
// every accept, and a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_tdest_tuser_swap_reg;
  localparam int BUS = 64;
  localparam int IDW = 4;
  localparam int DW  = 4;
  localparam int KW  = BUS / 8;
  localparam int PW  = BUS + IDW + DW + KW + 1;
`ifdef TDEST_TUSER_SWAP_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        dest_mismatch;
  logic [15:0] mismatch_count;
  logic        pkt_mid;

  logic [PW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int mm_pulses = 0;

  tdest_tuser_swap_if #(.AXIS_BUS_WIDTH(BUS), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DW)) bus ();

  tdest_tuser_swap_reg #(.AXIS_BUS_WIDTH(BUS), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DW)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .axis           (bus),
    .dest_mismatch  (dest_mismatch),
    .mismatch_count (mismatch_count),
    .pkt_mid        (pkt_mid)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic send(input logic [BUS-1:0] d, input logic [IDW-1:0] id, input logic [DW-1:0] dest,
                      input logic [KW-1:0] keep, input logic last, input logic [DW-1:0] exp_user);
    int n = 0;
    @(negedge aclk);
    bus.axis_in_tdata  = d;
    bus.axis_in_tid    = id;
    bus.axis_in_tdest  = dest;
    bus.axis_in_tkeep  = keep;
    bus.axis_in_tlast  = last;
    bus.axis_in_tvalid = 1'b1;
    while (!bus.axis_in_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!bus.axis_in_tready) begin
      check("send_tready_timeout", 128'(bus.axis_in_tready), 128'd1);
    end else begin
      @(posedge aclk);
      exp_q.push_back({d, id, exp_user, keep, last});
    end
    #1 bus.axis_in_tvalid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1 bus.axis_out_tready = v;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic pulse_reset();
    @(posedge aclk);
    #1 aresetn = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Scoreboard monitor
  logic [PW-1:0] held;
  logic          held_v = 1'b0;
  always @(negedge aclk) begin
    logic [PW-1:0] cur;
    logic [PW-1:0] e;
    if (!aresetn) begin
      held_v = 1'b0;
    end else begin
      if (dest_mismatch) mm_pulses++;
      cur = {bus.axis_out_tdata, bus.axis_out_tid, bus.axis_out_tuser, bus.axis_out_tkeep, bus.axis_out_tlast};
      if (held_v) check("hold_stable", 128'(cur), 128'(held));
      if (bus.axis_out_tvalid && bus.axis_out_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'(cur), 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 128'(cur), 128'(e));
        end
      end
      held_v = bus.axis_out_tvalid && !bus.axis_out_tready;
      held   = cur;
    end
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn              = 1'b0;
    bus.axis_in_tdata    = '0;
    bus.axis_in_tid      = '0;
    bus.axis_in_tdest    = '0;
    bus.axis_in_tkeep    = '0;
    bus.axis_in_tlast    = 1'b0;
    bus.axis_in_tvalid   = 1'b0;
    bus.axis_out_tready  = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_in_tready", 128'(bus.axis_in_tready), 128'd0);
    check("rst_out_tvalid", 128'(bus.axis_out_tvalid), 128'd0);
    check("rst_mismatch", 128'(dest_mismatch), 128'd0);
    check("rst_count", 128'(mismatch_count), 128'd0);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_in_tready", 128'(bus.axis_in_tready), 128'd1);

    // Single beat, one-cycle latency
    set_ready(1'b1);
    send(64'h0123_4567_89AB_CDEF, 4'h1, 4'h3, 8'hFF, 1'b1, 4'h3);
    @(negedge aclk);
    check("single_tvalid", 128'(bus.axis_out_tvalid), 128'd1);
    check("single_tuser", 128'(bus.axis_out_tuser), 128'h3);
    check("single_tdata", 128'(bus.axis_out_tdata), 128'h0123_4567_89AB_CDEF);
    wait_empty("single_drain");

    // Back-pressure: 4-beat packet with downstream stalled
    set_ready(1'b0);
    fork
      begin
        send(64'hA0A0_0000_0000_0001, 4'h2, 4'h9, 8'hFF, 1'b0, 4'h9);
        send(64'hA0A0_0000_0000_0002, 4'h2, 4'h9, 8'hFF, 1'b0, 4'h9);
        send(64'hA0A0_0000_0000_0003, 4'h2, 4'h9, 8'h0F, 1'b0, 4'h9);
        send(64'hA0A0_0000_0000_0004, 4'h2, 4'h9, 8'h03, 1'b1, 4'h9);
      end
      begin
        repeat (4) @(negedge aclk);
        check("bp_in_tready_low", 128'(bus.axis_in_tready), 128'd0);
        check("bp_out_tvalid", 128'(bus.axis_out_tvalid), 128'd1);
        check("bp_queued", 128'(exp_q.size()), 128'd2);
        repeat (3) @(negedge aclk);
        check("bp_in_tready_still_low", 128'(bus.axis_in_tready), 128'd0);
        set_ready(1'b1);
      end
    join
    wait_empty("bp_drain");

    // Packet lock: tdest 5,7,5
    @(negedge aclk);
    mm_pulses = 0;
    send(64'h5555_0000_0000_0001, 4'h3, 4'h5, 8'hFF, 1'b0, 4'h5);
    send(64'h5555_0000_0000_0002, 4'h3, 4'h7, 8'hFF, 1'b0, LOCK ? 4'h5 : 4'h7);
    @(negedge aclk);
    check("lock_pulse", 128'(dest_mismatch), LOCK ? 128'd1 : 128'd0);
    send(64'h5555_0000_0000_0003, 4'h3, 4'h5, 8'hFF, 1'b1, 4'h5);
    wait_empty("lock_drain");
    repeat (2) @(negedge aclk);
    check("lock_pulses", 128'(mm_pulses), LOCK ? 128'd1 : 128'd0);
    check("lock_count", 128'(mismatch_count), LOCK ? 128'd1 : 128'd0);

    // Reset mid-packet with two beats buffered
    set_ready(1'b0);
    send(64'hBEEF_0000_0000_0001, 4'h4, 4'hA, 8'hFF, 1'b0, 4'hA);
    send(64'hBEEF_0000_0000_0002, 4'h4, 4'hA, 8'hFF, 1'b0, 4'hA);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    check("midrst_out_tvalid", 128'(bus.axis_out_tvalid), 128'd0);
    check("midrst_count", 128'(mismatch_count), 128'd0);
    check("midrst_in_tready", 128'(bus.axis_in_tready), 128'd0);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_in_tready_back", 128'(bus.axis_in_tready), 128'd1);
    set_ready(1'b1);
    send(64'hC0DE_0000_0000_0001, 4'h5, 4'h2, 8'hFF, 1'b0, 4'h2);
    send(64'hC0DE_0000_0000_0002, 4'h5, 4'h4, 8'hFF, 1'b0, LOCK ? 4'h2 : 4'h4);
    send(64'hC0DE_0000_0000_0003, 4'h5, 4'h2, 8'h01, 1'b1, 4'h2);
    wait_empty("midrst_drain");
    repeat (2) @(negedge aclk);
    check("midrst_new_count", 128'(mismatch_count), LOCK ? 128'd1 : 128'd0);

    // Saturation of the mismatch counter
    pulse_reset();
    set_ready(1'b1);
    mm_pulses = 0;
    if (LOCK) begin
      send(64'd0, 4'h6, 4'h1, 8'hFF, 1'b0, 4'h1);
      for (int i = 1; i <= 65534; i++)
        send(64'(i), 4'h6, 4'h2, 8'hFF, 1'b0, 4'h1);
      wait_empty("sat_pre_drain");
      repeat (2) @(negedge aclk);
      check("sat_preload", 128'(mismatch_count), 128'd65534);
      for (int i = 0; i < 3; i++)
        send(64'hF000 + 64'(i), 4'h6, 4'h2, 8'hFF, 1'b0, 4'h1);
      send(64'hFFFF, 4'h6, 4'h1, 8'hFF, 1'b1, 4'h1);
      wait_empty("sat_drain");
      repeat (2) @(negedge aclk);
      check("sat_count", 128'(mismatch_count), 128'd65535);
      check("sat_pulses", 128'(mm_pulses), 128'd65537);
    end else begin
      send(64'h1, 4'h6, 4'h1, 8'hFF, 1'b0, 4'h1);
      for (int i = 0; i < 3; i++)
        send(64'h10 + 64'(i), 4'h6, 4'h2, 8'hFF, 1'b0, 4'h2);
      send(64'h2, 4'h6, 4'h1, 8'hFF, 1'b1, 4'h1);
      wait_empty("sat_drain");
      repeat (2) @(negedge aclk);
      check("sat_count", 128'(mismatch_count), 128'd0);
      check("sat_pulses", 128'(mm_pulses), 128'd0);
    end
    repeat (3) @(negedge aclk);
    check("sat_count_hold", 128'(mismatch_count), LOCK ? 128'd65535 : 128'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tdest_tuser_swap_reg.md
TDEST_TUSER_SWAP_REG -- requirements
Module: tdest_tuser_swap_reg

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_ID_WIDTH, default 4, tid width; the port width is max(1, value).
REQ-003 SHALL have parameter AXIS_DEST_WIDTH, default 4, input tdest and output tuser width; the port width is max(1, value).
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have ports axis_in_tdata/tid/tdest/tkeep/tlast/tvalid, input, widths BUS/ID/DEST/BUS/8/1/1, the upstream AXIS beat.
REQ-007 SHALL have port axis_in_tready, output, 1, upstream ready.
REQ-008 SHALL have ports axis_out_tdata/tid/tuser/tkeep/tlast/tvalid, output, widths BUS/ID/DEST/BUS/8/1/1, the downstream AXIS beat.
REQ-009 SHALL have port axis_out_tready, input, 1, downstream ready.
REQ-010 SHALL have port dest_mismatch, output, 1, a one-cycle pulse per accepted mid-packet beat whose tdest differs from the locked value.
REQ-011 SHALL have port mismatch_count, output, 16, a saturating count of dest_mismatch pulses.

Function
REQ-012 SHALL pass tdata, tid, tkeep and tlast through unchanged and drive axis_out_tuser from the tdest path; there is no axis_out_tdest.
REQ-013 SHALL register the stream through a 2-entry skid buffer: 1-cycle latency from input accept to axis_out_tvalid, and 1 beat/cycle sustained throughput.
REQ-014 SHALL drive axis_in_tready as a register equal to NOT(skid entry full); it SHALL NOT depend combinationally on axis_out_tready.
REQ-015 SHALL hold all axis_out_* signals stable while axis_out_tvalid=1 and axis_out_tready=0.
REQ-016 SHALL load an accepted beat into the output register when the output is empty or is draining that cycle, and otherwise into the skid entry.
REQ-017 SHALL, when the output drains while the skid entry is full, move the skid entry to the output and clear the skid entry in the same cycle.
REQ-018 SHALL, on a simultaneous accept and drain with the skid entry full, never lose a beat; this case cannot occur because axis_in_tready=0.
REQ-019 SHALL track packet position with the states SOP and MID: SOP->MID on an accepted beat with tlast=0; MID->SOP on an accepted beat with tlast=1; SOP->SOP on an accepted beat with tlast=1 (single-beat packet).
REQ-020 SHALL, in SOP, latch axis_in_tdest into lock_dest on accept and emit it as tuser for that beat.
REQ-021 SHALL, in MID, emit lock_dest as tuser regardless of the incoming tdest.
REQ-022 SHALL, in MID, pulse dest_mismatch one cycle after any accepted beat whose tdest differs from lock_dest.
REQ-023 SHALL increment mismatch_count by 1 per dest_mismatch pulse and hold it at 16'hFFFF once saturated (no wrap).

Reset
REQ-024 SHALL, while aresetn=0 at a clock edge: clear axis_out_tvalid, the skid entry, dest_mismatch, mismatch_count and lock_dest; set the state to SOP; and drive axis_in_tready=0.
REQ-025 SHALL drive axis_in_tready=1 on the first clock edge after aresetn returns to 1.
REQ-026 SHALL discard buffered beats and the partial-packet state on a reset asserted mid-packet; the next accepted beat is treated as SOP.
REQ-027 SHALL clear only the valid and state bits on reset; data registers are don't-care.

Configuration
REQ-028 SHALL, with macro TDEST_TUSER_SWAP_PKT_LOCK_EN defined, implement the packet lock of REQ-019..REQ-023.
REQ-029 SHALL, without TDEST_TUSER_SWAP_PKT_LOCK_EN defined: pass each beat's own tdest as tuser; tie dest_mismatch=0 and mismatch_count=0; omit the state and lock registers; keep the buffering identical.

Verification
REQ-030 SHALL cover single beat: tdest=4'h3, tlast=1, out_tready=1 -> the next cycle shows tuser=4'h3, tvalid=1, and tdata unchanged.
REQ-031 SHALL cover back-pressure: a 4-beat packet with out_tready=0 for beats 1-3 -> in_tready falls after 2 beats are accepted, no beat is lost or reordered, and the output is held stable.
REQ-032 SHALL cover packet lock (macro on): a 3-beat packet with tdest 5,7,5 -> tuser=5 on all 3 beats, one dest_mismatch pulse, mismatch_count=1.
REQ-033 SHALL cover macro off with the same stimulus as REQ-032 -> tuser=5,7,5 and dest_mismatch never asserted.
REQ-034 SHALL cover reset mid-packet: aresetn=0 for 1 cycle after beat 2 of 4 -> out_tvalid=0 and count=0; the next packet's first beat's tdest becomes its tuser.
REQ-035 SHALL cover saturation: preload to 65534, then 3 mismatching beats -> count reads 65535 and holds there.
